// File: rtl/alu_arbiter_if.sv
// Bundles the request ports, the external ALU hookup and the response/counter side of alu_arbiter.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 8
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [WIDTH-1:0]   req_opA0;
  logic [WIDTH-1:0]   req_opB0;
  logic [2:0]         req_cmd0;
  logic [WIDTH-1:0]   req_opA1;
  logic [WIDTH-1:0]   req_opB1;
  logic [2:0]         req_cmd1;
  logic [WIDTH-1:0]   alu_opA;
  logic [WIDTH-1:0]   alu_opB;
  logic [2:0]         alu_cmd;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_zero;
  logic               alu_ovf;
  logic               alu_cout;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;
  logic               rsp_ovf;
  logic               rsp_cout;
  logic [COUNT_W-1:0] done_cnt0;
  logic [COUNT_W-1:0] done_cnt1;

  modport slave (
    input  req_valid, req_opA0, req_opB0, req_cmd0, req_opA1, req_opB1, req_cmd1,
    output req_ready,
    output alu_opA, alu_opB, alu_cmd,
    input  alu_result, alu_zero, alu_ovf, alu_cout,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_cout,
    input  rsp_ready,
    output done_cnt0, done_cnt1
  );

  modport master (
    output req_valid, req_opA0, req_opB0, req_cmd0, req_opA1, req_opB1, req_cmd1,
    input  req_ready,
    input  alu_opA, alu_opB, alu_cmd,
    output alu_result, alu_zero, alu_ovf, alu_cout,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_cout,
    output rsp_ready,
    input  done_cnt0, done_cnt1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters,
// returning results through a registered valid/ready stage with per-port completion counters.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 8
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  localparam int unsigned CMD_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [CMD_W-1:0] cmd;
  } op_t;

  state_t             state;
  state_t             state_nx;
  op_t                op_q;
  op_t                op_sel;
  logic               id_q;
  logic               last_q;
  logic               grant_id;
  logic               do_grant;
  logic               rsp_fire;
  logic [1:0]         req_ready_c;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic               rsp_zero_q;
  logic               rsp_ovf_q;
  logic               rsp_cout_q;
  logic [COUNT_W-1:0] cnt0_q;
  logic [COUNT_W-1:0] cnt1_q;

  // Next-state, grant decision and handshake strobes
  always_comb begin
    state_nx    = state;
    req_ready_c = 2'b00;
    grant_id    = 1'b0;
    do_grant    = 1'b0;
    rsp_fire    = 1'b0;
    case (state)
      IDLE: begin
        grant_id = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
        if (!reset && (|bus.req_valid)) begin
          do_grant    = 1'b1;
          req_ready_c = grant_id ? 2'b10 : 2'b01;
          state_nx    = ISSUE;
        end
      end
      ISSUE: state_nx = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    op_sel = grant_id ? {bus.req_opA1, bus.req_opB1, bus.req_cmd1}
                      : {bus.req_opA0, bus.req_opB0, bus.req_cmd0};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand capture, response stage and saturating completion counters
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= '0;
      id_q         <= 1'b0;
      last_q       <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_cout_q   <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      if (do_grant) begin
        op_q   <= op_sel;
        id_q   <= grant_id;
        last_q <= grant_id;
      end
      if (state == ISSUE) begin
        rsp_valid_q  <= 1'b1;
        rsp_result_q <= bus.alu_result;
        rsp_zero_q   <= bus.alu_zero;
        rsp_ovf_q    <= bus.alu_ovf;
        rsp_cout_q   <= bus.alu_cout;
      end
      if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
        if (!id_q && (cnt0_q != '1)) cnt0_q <= cnt0_q + COUNT_W'(1);
        if (id_q && (cnt1_q != '1))  cnt1_q <= cnt1_q + COUNT_W'(1);
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.alu_opA    = op_q.opa;
  assign bus.alu_opB    = op_q.opb;
  assign bus.alu_cmd    = op_q.cmd;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.done_cnt0  = cnt0_q;
  assign bus.done_cnt1  = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checked every cycle on two instances
// (8-bit and 2-bit counters) plus hand-computed expectations for the directed scenarios.
module tb_alu_arbiter;
  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        c;
  } alu_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  cmd;
  } op_t;

  typedef struct {
    int          cyc;
    logic        id;
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        c;
  } rsp_t;

  logic clk;
  logic reset;
  logic rsp_ready;

  alu_arbiter_if #(.WIDTH(32), .COUNT_W(8)) m();
  alu_arbiter_if #(.WIDTH(32), .COUNT_W(2)) s();

  alu_arbiter #(.WIDTH(32), .COUNT_W(8)) u_main  (.clk(clk), .reset(reset), .bus(m));
  alu_arbiter #(.WIDTH(32), .COUNT_W(2)) u_small (.clk(clk), .reset(reset), .bus(s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU, also serving as the external ALU for both instances
  function automatic alu_t alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
    alu_t r;
    logic [32:0] sum;
    r = '0;
    case (cmd)
      3'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        r.r = sum[31:0]; r.c = sum[32];
        r.o = (a[31] == b[31]) && (r.r[31] != a[31]);
      end
      3'd1: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.r = sum[31:0]; r.c = sum[32];
        r.o = (a[31] != b[31]) && (r.r[31] != a[31]);
      end
      3'd2: r.r = a ^ b;
      3'd3: r.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r.r = a & b;
      3'd5: r.r = ~(a & b);
      3'd6: r.r = ~(a | b);
      default: r.r = a | b;
    endcase
    r.z = (r.r == 32'd0);
    return r;
  endfunction

  assign {m.alu_result, m.alu_zero, m.alu_ovf, m.alu_cout} = alu_f(m.alu_opA, m.alu_opB, m.alu_cmd);
  assign {s.alu_result, s.alu_zero, s.alu_ovf, s.alu_cout} = alu_f(s.alu_opA, s.alu_opB, s.alu_cmd);

  assign m.rsp_ready = rsp_ready;
  assign s.rsp_ready = rsp_ready;
  assign s.req_valid = m.req_valid;
  assign s.req_opA0  = m.req_opA0;
  assign s.req_opB0  = m.req_opB0;
  assign s.req_cmd0  = m.req_cmd0;
  assign s.req_opA1  = m.req_opA1;
  assign s.req_opB1  = m.req_opB1;
  assign s.req_cmd1  = m.req_cmd1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit armed    = 0;

  op_t  q0[$];
  op_t  q1[$];
  rsp_t rlog[$];
  int   glog[$];
  int   lat[$];
  int   last_acc = 0;
  logic prev_v   = 1'b0;

  // Model: one outstanding transaction; age 1 = on the ALU, age 2 = response presented
  bit          m_busy;
  int          m_age;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_cmd;
  logic        m_last;
  logic        m_id;
  int          m_cnt[2];
  alu_t        m_rsp;
  bit          m_fresh;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int grant_of(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 0 : 1;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic check_outputs();
    int g;
    logic [1:0] er;
    logic ev;
    g  = grant_of(m.req_valid, m_last);
    er = (reset || m_busy || g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
    ev = m_busy && (m_age == 2);
    chk("req_ready", 64'(m.req_ready), 64'(er));
    chk("alu_opA", 64'(m.alu_opA), 64'(m_a));
    chk("alu_opB", 64'(m.alu_opB), 64'(m_b));
    chk("alu_cmd", 64'(m.alu_cmd), 64'(m_cmd));
    chk("rsp_valid", 64'(m.rsp_valid), 64'(ev));
    chk("done_cnt0", 64'(m.done_cnt0), 64'(sat(m_cnt[0], 8)));
    chk("done_cnt1", 64'(m.done_cnt1), 64'(sat(m_cnt[1], 8)));
    if (ev || m_fresh) begin
      chk("rsp_id", 64'(m.rsp_id), 64'(m_fresh ? 1'b0 : m_id));
      chk("rsp_result", 64'(m.rsp_result), 64'(m_rsp.r));
      chk("rsp_zero", 64'(m.rsp_zero), 64'(m_rsp.z));
      chk("rsp_ovf", 64'(m.rsp_ovf), 64'(m_rsp.o));
      chk("rsp_cout", 64'(m.rsp_cout), 64'(m_rsp.c));
      chk("small_rsp_result", 64'(s.rsp_result), 64'(m_rsp.r));
    end
    chk("small_req_ready", 64'(s.req_ready), 64'(er));
    chk("small_rsp_valid", 64'(s.rsp_valid), 64'(ev));
    chk("small_done_cnt0", 64'(s.done_cnt0), 64'(sat(m_cnt[0], 2)));
    chk("small_done_cnt1", 64'(s.done_cnt1), 64'(sat(m_cnt[1], 2)));
  endtask

  task automatic model_step(input logic rst, input logic [1:0] v, input logic rr, input op_t o0, input op_t o1);
    int g;
    op_t o;
    if (rst) begin
      m_busy = 0; m_age = 0; m_a = '0; m_b = '0; m_cmd = '0; m_last = 1'b1; m_id = 1'b0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_rsp = '0; m_fresh = 1; armed = 1;
    end else if (m_busy) begin
      if (m_age == 1) begin
        m_age = 2;
        m_rsp = alu_f(m_a, m_b, m_cmd);
      end else if (rr) begin
        m_cnt[m_id] = m_cnt[m_id] + 1;
        m_busy = 0;
      end
    end else begin
      g = grant_of(v, m_last);
      if (g >= 0) begin
        o = (g == 1) ? o1 : o0;
        m_a = o.a; m_b = o.b; m_cmd = o.cmd;
        m_id = (g == 1); m_last = (g == 1);
        m_busy = 1; m_age = 1; m_fresh = 0;
      end
    end
  endtask

  function automatic op_t front(input int p);
    op_t z;
    z = '{a: '0, b: '0, cmd: '0};
    if (p == 0 && q0.size() > 0) return q0[0];
    if (p == 1 && q1.size() > 0) return q1[0];
    return z;
  endfunction

  task automatic drive();
    op_t o0, o1;
    o0 = front(0);
    o1 = front(1);
    m.req_valid = {q1.size() > 0, q0.size() > 0};
    m.req_opA0 = o0.a; m.req_opB0 = o0.b; m.req_cmd0 = o0.cmd;
    m.req_opA1 = o1.a; m.req_opB1 = o1.b; m.req_cmd1 = o1.cmd;
  endtask

  task automatic push(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
    op_t o;
    o = '{a: a, b: b, cmd: cmd};
    if (p == 0) q0.push_back(o);
    else        q1.push_back(o);
    drive();
  endtask

  // One clock: compare at negedge, then advance model and requesters just after posedge
  task automatic cycle();
    logic       s_rst, s_rr;
    logic [1:0] s_v, s_rdy;
    op_t        o0, o1;
    rsp_t       e;
    @(negedge clk);
    if (armed) check_outputs();
    s_rst = reset; s_rr = rsp_ready; s_v = m.req_valid; s_rdy = m.req_ready;
    o0 = front(0); o1 = front(1);
    if (s_rdy != 2'b00) begin
      glog.push_back(s_rdy[1] ? 1 : 0);
      last_acc = cyc;
    end
    if (m.rsp_valid && !prev_v) lat.push_back(cyc - last_acc);
    prev_v = m.rsp_valid;
    if (m.rsp_valid && rsp_ready) begin
      e = '{cyc: cyc, id: m.rsp_id, r: m.rsp_result, z: m.rsp_zero, o: m.rsp_ovf, c: m.rsp_cout};
      rlog.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    model_step(s_rst, s_v, s_rr, o0, o1);
    if (s_rdy[0] && q0.size() > 0) void'(q0.pop_front());
    if (s_rdy[1] && q1.size() > 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    while (rlog.size() < n && t < 60) begin
      cycle();
      t++;
    end
    if (rlog.size() < n) begin
      n_err++;
      $display("FAIL wait_rsp: got %0d responses expected %0d", rlog.size(), n);
    end
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!m.rsp_valid && t < 20) begin
      cycle();
      t++;
    end
    n_checks++;
    if (!m.rsp_valid) begin
      n_err++;
      $display("FAIL wait_valid: rsp_valid got 0 expected 1");
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    rlog.delete();
    glog.delete();
    lat.delete();
  endtask

  initial begin
    int exp_cnt[5];
    exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 3; exp_cnt[4] = 3;
    reset = 1'b1;
    rsp_ready = 1'b1;
    drive();
    cycle();

    // Request presented while reset is high is not granted
    push(0, 32'h7fffffff, 32'h00000001, 3'd0);
    cycle();
    chk("lit_no_grant_in_reset", 64'(m.req_ready), 64'(2'b00));
    chk("lit_reset_cnt0", 64'(m.done_cnt0), 64'd0);
    reset = 1'b0;
    rlog.delete(); glog.delete(); lat.delete();

    // Signed overflow on ADD
    wait_rsp(1);
    chk("lit_add_result", 64'(rlog[0].r), 64'h80000000);
    chk("lit_add_ovf", 64'(rlog[0].o), 64'd1);
    chk("lit_add_cout", 64'(rlog[0].c), 64'd0);
    chk("lit_add_zero", 64'(rlog[0].z), 64'd0);
    chk("lit_add_id", 64'(rlog[0].id), 64'd0);
    chk("lit_latency", 64'(lat[0]), 64'd2);
    chk("lit_cnt0_after_one", 64'(m.done_cnt0), 64'd1);

    // Round-robin between two busy ports
    reset = 1'b1;
    push(0, 32'h00000006, 32'h00000002, 3'd1);
    push(1, 32'hffffffff, 32'h001d0987, 3'd2);
    push(0, 32'h00000001, 32'h00000001, 3'd0);
    push(1, 32'h00000005, 32'h00000003, 3'd4);
    reset_pulse();
    wait_rsp(4);
    chk("lit_rr_g0", 64'(glog[0]), 64'd0);
    chk("lit_rr_g1", 64'(glog[1]), 64'd1);
    chk("lit_rr_g2", 64'(glog[2]), 64'd0);
    chk("lit_rr_g3", 64'(glog[3]), 64'd1);
    chk("lit_sub_result", 64'(rlog[0].r), 64'h4);
    chk("lit_sub_cout", 64'(rlog[0].c), 64'd1);
    chk("lit_xor_result", 64'(rlog[1].r), 64'hffe2f678);
    chk("lit_xor_id", 64'(rlog[1].id), 64'd1);
    chk("lit_add2_result", 64'(rlog[2].r), 64'h2);
    chk("lit_and_result", 64'(rlog[3].r), 64'h1);
    chk("lit_spacing", 64'(rlog[3].cyc - rlog[2].cyc), 64'd3);
    chk("lit_spacing_b", 64'(rlog[1].cyc - rlog[0].cyc), 64'd3);

    // SLT on negative operands and an XOR producing zero
    rlog.delete();
    push(1, 32'hfffffe3e, 32'hffffffde, 3'd3);
    push(1, 32'h00000064, 32'h00000064, 3'd2);
    wait_rsp(2);
    chk("lit_slt_result", 64'(rlog[0].r), 64'h1);
    chk("lit_slt_zero", 64'(rlog[0].z), 64'd0);
    chk("lit_xz_result", 64'(rlog[1].r), 64'h0);
    chk("lit_xz_zero", 64'(rlog[1].z), 64'd1);

    // Backpressure: response held while port 0 keeps asking
    reset_pulse();
    rsp_ready = 1'b0;
    push(0, 32'h00000003, 32'h00000004, 3'd7);
    push(0, 32'h00000008, 32'h00000008, 3'd0);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("lit_hold_ready", 64'(m.req_ready), 64'(2'b00));
      chk("lit_hold_result", 64'(m.rsp_result), 64'h7);
    end
    chk("lit_hold_cnt0", 64'(m.done_cnt0), 64'd0);
    rsp_ready = 1'b1;
    cycle();
    chk("lit_regrant_p0", 64'(m.req_ready), 64'(2'b01));
    chk("lit_hold_cnt0_after", 64'(m.done_cnt0), 64'd1);
    wait_rsp(2);

    // Reset in RESP with counters at 3/2
    reset_pulse();
    push(0, 32'h1, 32'h1, 3'd0);
    push(0, 32'h2, 32'h1, 3'd0);
    push(0, 32'h3, 32'h1, 3'd0);
    push(1, 32'h4, 32'h1, 3'd0);
    push(1, 32'h5, 32'h1, 3'd0);
    wait_rsp(5);
    cycle();
    chk("lit_cnt0_3", 64'(m.done_cnt0), 64'd3);
    chk("lit_cnt1_2", 64'(m.done_cnt1), 64'd2);
    rsp_ready = 1'b0;
    push(0, 32'h0000abcd, 32'h00001234, 3'd7);
    wait_valid();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("lit_rst_rsp_valid", 64'(m.rsp_valid), 64'd0);
    chk("lit_rst_cnt0", 64'(m.done_cnt0), 64'd0);
    chk("lit_rst_cnt1", 64'(m.done_cnt1), 64'd0);
    chk("lit_rst_alu_cmd", 64'(m.alu_cmd), 64'd0);
    chk("lit_rst_alu_opA", 64'(m.alu_opA), 64'd0);
    glog.delete();
    rlog.delete();
    rsp_ready = 1'b1;
    push(0, 32'h10, 32'h20, 3'd7);
    push(1, 32'h30, 32'h40, 3'd7);
    cycle();
    chk("lit_tie_after_reset", 64'((glog.size() > 0) ? glog[0] : 9), 64'd0);
    wait_rsp(2);

    // Saturation of the 2-bit counter instance
    reset_pulse();
    for (int k = 0; k < 5; k++) begin
      push(0, 32'(k), 32'h1, 3'd0);
      wait_rsp(k + 1);
      chk("lit_small_sat", 64'(s.done_cnt0), 64'(exp_cnt[k]));
    end
    chk("lit_main_cnt0_5", 64'(m.done_cnt0), 64'd5);

    repeat (3) cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
